// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program loader/verifier and the 32 x 8 processor memory port.
package mem_loader_pkg;

  localparam int unsigned MEM_AW = 5;
  localparam int unsigned MEM_DW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StDrain,
    StFin
  } state_e;

endpackage

// File: rtl/mem_loader.sv
// Streams bytes into memory from a base address, reads the region back and compares
// additive checksums of the written and read-back bytes.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] load_sum,
  output logic [DW-1:0] read_sum
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, base_q, base_d;
  logic [AW:0]   rem_q, rem_d, len_q, len_d;
  logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cap_vld_q;
  logic          done_q, done_d, err_q, err_d;
  logic [DW-1:0] load_sum_q, load_sum_d, read_sum_q, read_sum_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    base_d      = base_q;
    rem_d       = rem_q;
    len_d       = len_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    load_sum_d  = load_sum_q;
    // Read data lags mem_rd by one cycle; cap_vld qualifies it.
    read_sum_d  = cap_vld_q ? read_sum_q + mem_rdata : read_sum_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = base_addr;
          len_d      = len;
          ptr_d      = base_addr;
          rem_d      = len;
          load_sum_d = '0;
          read_sum_d = '0;
          err_d      = 1'b0;
          if (len == '0) begin
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_data;
          load_sum_d  = load_sum_q + in_data;
          ptr_d       = ptr_q + AW'(1);
          rem_d       = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            ptr_d   = base_q;
            rem_d   = len_q;
            state_d = StVerify;
          end
        end
      end
      StVerify: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = ptr_q;
        ptr_d      = ptr_q + AW'(1);
        rem_d      = rem_q - (AW+1)'(1);
        if (rem_q == (AW+1)'(1)) state_d = StDrain;
      end
      StDrain: state_d = StFin;
      StFin: begin
        state_d = StIdle;
        // The empty-load case already pulsed done on entry to FIN.
        if (len_q != '0) begin
          done_d = 1'b1;
          err_d  = (load_sum_q != read_sum_d);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      base_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cap_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_sum_q  <= '0;
      read_sum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      base_q      <= base_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cap_vld_q   <= mem_rd_q;
      done_q      <= done_d;
      err_q       <= err_d;
      load_sum_q  <= load_sum_d;
      read_sum_q  <= read_sum_d;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_sum  = load_sum_q;
  assign read_sum  = read_sum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a 32 x 8 memory model behind the port.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, err;
  logic [7:0] load_sum, read_sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [32];
  bit         corrupt = 1'b0;

  mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_sum  (load_sum),
    .read_sum  (read_sum)
  );

  always #5 clk = ~clk;

  // Memory returns read data one cycle after sampling rd; optional corruption of address 06.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= (corrupt && mem_addr == 5'h06) ? 8'h00 : mem[mem_addr];
  end

  typedef struct {
    logic [4:0]       base;
    logic [5:0]       len;
    logic [31:0][7:0] data;
    int               gap_at;
    int               gap;
    bit               corrupt;
    bit               start_mid;
    logic [7:0]       exp_load;
    logic [7:0]       exp_read;
    bit               exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int idx      = 0;
    int gap_left = 0;
    int done_cyc = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int both_cnt = 0;
    logic [4:0] a;
    corrupt = v.corrupt;
    @(posedge clk); #1;
    base_addr = v.base;
    len       = v.len;
    start     = 1'b1;
    in_valid  = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.start_mid && c == 2) begin
        start     = 1'b1;
        base_addr = 5'h00;
        len       = 6'd0;
      end
      if (mem_wr) wr_cnt++;
      if (mem_rd) rd_cnt++;
      if (mem_wr && mem_rd) both_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else if (idx < int'(v.len)) begin
        in_valid = 1'b1;
        in_data  = v.data[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        idx++;
        if (v.gap > 0 && idx == v.gap_at) gap_left = v.gap;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check($sformatf("v%0d latency", k), done_cyc, v.exp_lat);
    check($sformatf("v%0d load_sum", k), load_sum, v.exp_load);
    check($sformatf("v%0d read_sum", k), read_sum, v.exp_read);
    check($sformatf("v%0d err", k), err, v.exp_err);
    check($sformatf("v%0d in_ready_at_done", k), in_ready, 0);
    check($sformatf("v%0d wr_strobes", k), wr_cnt, v.len);
    check($sformatf("v%0d rd_strobes", k), rd_cnt, v.len);
    check($sformatf("v%0d rd_wr_overlap", k), both_cnt, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d done_pulse_busy", k), {done, busy}, 2'b00);
    check($sformatf("v%0d sums_held", k), {load_sum, read_sum, err},
          {v.exp_load, v.exp_read, v.exp_err});
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 5'(i);
      check($sformatf("v%0d mem[%0h]", k, a), mem[a], v.data[i]);
    end
  endtask

  initial begin
    // Basic load
    vt[0] = '{base: 5'h05, len: 6'd2, data: '0, gap_at: 0, gap: 0, corrupt: 0, start_mid: 0,
              exp_load: 8'h4F, exp_read: 8'h4F, exp_err: 0, exp_lat: 7};
    vt[0].data[0] = 8'hA5;
    vt[0].data[1] = 8'hAA;
    // Back-pressure: 3-cycle gap after the first byte, plus a start pulse inside LOAD
    vt[1] = vt[0];
    vt[1].gap_at    = 1;
    vt[1].gap       = 3;
    vt[1].start_mid = 1;
    vt[1].exp_lat   = 10;
    // Address wrap
    vt[2] = '{base: 5'h1E, len: 6'd4, data: '0, gap_at: 0, gap: 0, corrupt: 0, start_mid: 0,
              exp_load: 8'h0A, exp_read: 8'h0A, exp_err: 0, exp_lat: 11};
    for (int i = 0; i < 4; i++) vt[2].data[i] = 8'(i + 1);
    // Read corruption at 06
    vt[3] = vt[0];
    vt[3].corrupt  = 1;
    vt[3].exp_read = 8'hA5;
    vt[3].exp_err  = 1;
    // Empty load
    vt[4] = '{base: 5'h03, len: 6'd0, data: '0, gap_at: 0, gap: 0, corrupt: 0, start_mid: 0,
              exp_load: 8'h00, exp_read: 8'h00, exp_err: 0, exp_lat: 1};
    // Full memory
    vt[5] = '{base: 5'h00, len: 6'd32, data: '0, gap_at: 0, gap: 0, corrupt: 0, start_mid: 0,
              exp_load: 8'hF0, exp_read: 8'hF0, exp_err: 0, exp_lat: 67};
    for (int i = 0; i < 32; i++) vt[5].data[i] = 8'(i);

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ctrl", {in_ready, busy, done, err, mem_rd, mem_wr}, 6'b0);
    check("reset_data", {mem_addr, mem_wdata, load_sum, read_sum}, 29'b0);

    for (int k = 0; k < 6; k++) run_vec(k, vt[k]);

    // Reset mid-LOAD: write strobe must drop without waiting for a clock edge
    corrupt = 1'b0;
    @(posedge clk); #1;
    base_addr = 5'h10;
    len       = 6'd4;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    check("pre_rst_wr_busy", {mem_wr, busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wr_busy", {mem_wr, busy}, 2'b00);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_ready", in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
